// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_pkg
// Purpose  : Shared definitions for the multiply/divide sequencer. Provides
//            the default operand width, the op encoding, and the FSM state
//            encoding.
// Revision : 1.0 - initial release
// ============================================================================
package md_pkg;

  localparam int MD_WIDTH = 32;

  // Op encoding, sampled together with start
  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  // Sequencer states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MULT = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage
`default_nettype wire

// File: rtl/mult_div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_ctrl_if
// Purpose  : Request/result bundle between the control unit and the
//            multiply/divide sequencer.
//   master : drives start, op, a_in, b_in; observes busy/done/div0/results
//   slave  : the sequencer side
// Revision : 1.0 - initial release
// ============================================================================
interface mult_div_ctrl_if
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             hi_write;
  logic             lo_write;

  modport master (
    output start, op, a_in, b_in,
    input  busy, done, div0, hi_out, lo_out, hi_write, lo_write
  );

  modport slave (
    input  start, op, a_in, b_in,
    output busy, done, div0, hi_out, lo_out, hi_write, lo_write
  );

endinterface
`default_nettype wire

// File: rtl/md_div_step.sv
`default_nettype none
// ============================================================================
// Module   : md_div_step
// Purpose  : One combinational restoring-division step on unsigned
//            magnitudes. Shifts the next dividend bit into the partial
//            remainder, subtracts the divisor when it fits, and shifts the
//            resulting quotient bit into the quotient register.
//   i_rem      partial remainder (always < i_divisor)
//   i_quo      dividend bits not yet consumed / quotient bits produced
//   i_divisor  divisor magnitude
//   o_remNext  updated partial remainder
//   o_quoNext  updated quotient/dividend register
// Revision : 1.0 - initial release
// ============================================================================
module md_div_step
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  wire logic [WIDTH-1:0] i_rem,
  input  wire logic [WIDTH-1:0] i_quo,
  input  wire logic [WIDTH-1:0] i_divisor,
  output logic      [WIDTH-1:0] o_remNext,
  output logic      [WIDTH-1:0] o_quoNext
);

  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_trial = {i_rem, i_quo[WIDTH-1]};
    w_diff  = w_trial - {1'b0, i_divisor};
    // Trial < 2*divisor, so the top bit of the difference is a clean borrow
    if (w_diff[WIDTH]) begin
      o_remNext = w_trial[WIDTH-1:0];
      o_quoNext = {i_quo[WIDTH-2:0], 1'b0};
    end else begin
      o_remNext = w_diff[WIDTH-1:0];
      o_quoNext = {i_quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_ctrl
// Purpose  : Sequencer for the iterative multiply/divide resource. Runs a
//            signed radix-2 Booth multiply or a signed restoring divide over
//            WIDTH steps, then pulses HI/LO write enables. Divide by zero
//            finishes immediately with div0 and no register writes.
//   clock  rising-edge clock
//   reset  asynchronous active-high reset
//   bus    slave side of mult_div_ctrl_if (start/op/a_in/b_in in,
//          busy/done/div0/hi_out/lo_out/hi_write/lo_write out, all registered)
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_ctrl
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input wire logic        clock,
  input wire logic        reset,
  mult_div_ctrl_if.slave  bus
);

  logic [2:0]       r_state;
  logic [2:0]       w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  // Booth uses r_acc as a WIDTH+1 accumulator so subtracting the most
  // negative multiplicand cannot overflow. Divide reuses its low WIDTH bits
  // as the partial remainder, r_q as dividend/quotient, r_m as divisor.
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic             r_q1;
  logic             r_negQuo;
  logic             r_negRem;

  logic             r_busy, r_done, r_div0, r_hiWrite, r_loWrite;
  logic [WIDTH-1:0] r_hiOut, r_loOut;
  logic             w_busyNext, w_doneNext, w_div0Next, w_writeNext;

  logic [WIDTH:0]     w_mExt;
  logic [WIDTH:0]     w_accSum;
  logic [2*WIDTH+1:0] w_boothShift;
  logic [WIDTH-1:0]   w_remNext, w_quoNext;
  logic [WIDTH-1:0]   w_aAbs, w_bAbs;

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_aAbs = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
  assign w_bAbs = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;

  // Booth step: add/subtract per {q0, q-1}, then arithmetic shift of {acc, q, q-1}
  always_comb begin
    w_mExt = {r_m[WIDTH-1], r_m};
    case ({r_q[0], r_q1})
      2'b01:   w_accSum = r_acc + w_mExt;
      2'b10:   w_accSum = r_acc - w_mExt;
      default: w_accSum = r_acc;
    endcase
    w_boothShift = {w_accSum[WIDTH], w_accSum, r_q};
  end

  md_div_step #(.WIDTH(WIDTH)) u_divStep (
    .i_rem     (r_acc[WIDTH-1:0]),
    .i_quo     (r_q),
    .i_divisor (r_m),
    .o_remNext (w_remNext),
    .o_quoNext (w_quoNext)
  );

  // State register together with the registered status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_div0    <= 1'b0;
      r_hiWrite <= 1'b0;
      r_loWrite <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
      r_div0    <= w_div0Next;
      r_hiWrite <= w_writeNext;
      r_loWrite <= w_writeNext;
    end
  end

  // Next-state logic
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.op == MD_MULT)  w_stateNext = ST_MULT;
          else if (bus.b_in == '0) w_stateNext = ST_DONE;
          else                     w_stateNext = ST_DIV;
        end
      end
      ST_MULT: if (w_last) w_stateNext = ST_DONE;
      ST_DIV:  if (w_last) w_stateNext = ST_FIX;
      ST_FIX:  w_stateNext = ST_DONE;
      ST_DONE: w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state; the only IDLE->DONE path is div by zero
  always_comb begin
    w_busyNext  = (w_stateNext == ST_MULT) || (w_stateNext == ST_DIV) ||
                  (w_stateNext == ST_FIX);
    w_doneNext  = (w_stateNext == ST_DONE);
    w_div0Next  = (r_state == ST_IDLE) && (w_stateNext == ST_DONE);
    w_writeNext = w_doneNext && !w_div0Next;
  end

  // Datapath
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_q1     <= 1'b0;
      r_negQuo <= 1'b0;
      r_negRem <= 1'b0;
      r_hiOut  <= '0;
      r_loOut  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_q1  <= 1'b0;
            if (bus.op == MD_MULT) begin
              r_q <= bus.b_in;
              r_m <= bus.a_in;
            end else begin
              r_q      <= w_aAbs;
              r_m      <= w_bAbs;
              r_negQuo <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
              r_negRem <= bus.a_in[WIDTH-1];
            end
          end
        end
        ST_MULT: begin
          r_acc <= w_boothShift[2*WIDTH+1:WIDTH+1];
          r_q   <= w_boothShift[WIDTH:1];
          r_q1  <= w_boothShift[0];
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_hiOut <= w_boothShift[2*WIDTH:WIDTH+1];
            r_loOut <= w_boothShift[WIDTH:1];
          end
        end
        ST_DIV: begin
          r_acc <= {1'b0, w_remNext};
          r_q   <= w_quoNext;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_FIX: begin
          r_loOut <= r_negQuo ? -r_q : r_q;
          r_hiOut <= r_negRem ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div0     = r_div0;
  assign bus.hi_write = r_hiWrite;
  assign bus.lo_write = r_loWrite;
  assign bus.hi_out   = r_hiOut;
  assign bus.lo_out   = r_loOut;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_ctrl
// Purpose  : Self-checking bench for mult_div_ctrl. A behavioural model
//            computes products/quotients with 64-bit signed arithmetic and
//            tracks the HI/LO register contents; latencies come from the
//            documented done cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_ctrl;
  import md_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_div_ctrl_if #(.WIDTH(32)) bus();

  mult_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model state: current HI/LO contents
  logic [31:0] mHi = '0, mLo = '0;
  // Expected values for the current operation
  logic [31:0] eHi, eLo;
  logic        eDiv0;
  int          eLat;
  // Observed values for the current operation
  logic [31:0] oHi, oLo;
  logic        oDiv0, oHw, oLw, oBusy1;
  int          oLat, oWidth;

  task automatic ref_model(input logic o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, qq, rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == MD_MULT) begin
      p = sa * sb;
      eHi = p[63:32]; eLo = p[31:0]; eDiv0 = 1'b0; eLat = 33;
    end else if (b == 32'd0) begin
      eHi = mHi; eLo = mLo; eDiv0 = 1'b1; eLat = 1;
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      eHi = rr[31:0]; eLo = qq[31:0]; eDiv0 = 1'b0; eLat = 34;
    end
    mHi = eHi;
    mLo = eLo;
  endtask

  // Present a one-cycle start; operands are scrambled right after acceptance
  task automatic launch(input logic o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a_in = a; bus.b_in = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.op = 1'($urandom); bus.a_in = $urandom; bus.b_in = $urandom;
  endtask

  // Called at the negedge after the accepting edge (latency 1)
  task automatic wait_done(input int pokeAt);
    int lat;
    lat = 1;
    oBusy1 = bus.busy;
    while (bus.done !== 1'b1 && lat < 60) begin
      if (lat == pokeAt) begin
        bus.start = 1'b1; bus.op = 1'($urandom); bus.a_in = $urandom; bus.b_in = $urandom;
      end
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
    oLat = lat;
    oHi = bus.hi_out; oLo = bus.lo_out;
    oDiv0 = bus.div0; oHw = bus.hi_write; oLw = bus.lo_write;
    oWidth = 1;
    @(negedge clk);
    if (bus.done === 1'b1) oWidth = 2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.a_in = '0; bus.b_in = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.div0, bus.hi_write, bus.lo_write} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 00000",
               {bus.busy, bus.done, bus.div0, bus.hi_write, bus.lo_write});
    end
    total++;
    if ({bus.hi_out, bus.lo_out} !== 64'd0) begin
      bad++;
      $display("FAIL reset_results: got hi=%h lo=%h want 0", bus.hi_out, bus.lo_out);
    end
    rst = 1'b0;
    mHi = '0; mLo = '0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    logic [31:0] da [4] = '{32'd7, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] db [4] = '{32'd6, 32'd5,        32'h80000000, 32'h7FFFFFFF};
    logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin a = da[i]; b = db[i]; end
      else begin a = $urandom; b = $urandom; end
      ref_model(MD_MULT, a, b);
      launch(MD_MULT, a, b);
      wait_done(0);
      total++;
      if (oLat != eLat || oWidth != 1) begin
        bad++;
        $display("FAIL mult_timing: got lat=%0d width=%0d want lat=%0d width=1", oLat, oWidth, eLat);
      end
      total++;
      if ({oHi, oLo} !== {eHi, eLo}) begin
        bad++;
        $display("FAIL mult_result %h*%h: got hi=%h lo=%h want hi=%h lo=%h", a, b, oHi, oLo, eHi, eLo);
      end
      total++;
      if ({oHw, oLw, oDiv0, oBusy1} !== 4'b1101) begin
        bad++;
        $display("FAIL mult_flags: got hw,lw,div0,busy=%b want 1101", {oHw, oLw, oDiv0, oBusy1});
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] da [5] = '{32'd7, 32'hFFFFFFF9, 32'h80000000, 32'd7,        32'hFFFFFFF9};
    logic [31:0] db [5] = '{32'd2, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE};
    logic [31:0] a, b;
    for (int i = 0; i < 11; i++) begin
      if (i < 5) begin a = da[i]; b = db[i]; end
      else begin
        a = $urandom;
        b = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
        if (b == 32'd0) b = 32'd3;
      end
      ref_model(MD_DIV, a, b);
      launch(MD_DIV, a, b);
      wait_done(0);
      total++;
      if (oLat != eLat || oWidth != 1) begin
        bad++;
        $display("FAIL div_timing: got lat=%0d width=%0d want lat=%0d width=1", oLat, oWidth, eLat);
      end
      total++;
      if ({oHi, oLo} !== {eHi, eLo}) begin
        bad++;
        $display("FAIL div_result %h/%h: got hi=%h lo=%h want hi=%h lo=%h", a, b, oHi, oLo, eHi, eLo);
      end
      total++;
      if ({oHw, oLw, oDiv0, oBusy1} !== 4'b1101) begin
        bad++;
        $display("FAIL div_flags: got hw,lw,div0,busy=%b want 1101", {oHw, oLw, oDiv0, oBusy1});
      end
    end
  endtask

  task automatic test_div0();
    ref_model(MD_DIV, 32'd5, 32'd0);
    launch(MD_DIV, 32'd5, 32'd0);
    wait_done(0);
    total++;
    if (oLat != 1 || oWidth != 1) begin
      bad++;
      $display("FAIL div0_timing: got lat=%0d width=%0d want lat=1 width=1", oLat, oWidth);
    end
    total++;
    if ({oHw, oLw, oDiv0, oBusy1} !== 4'b0010) begin
      bad++;
      $display("FAIL div0_flags: got hw,lw,div0,busy=%b want 0010", {oHw, oLw, oDiv0, oBusy1});
    end
    total++;
    if ({oHi, oLo} !== {eHi, eLo}) begin
      bad++;
      $display("FAIL div0_keep: got hi=%h lo=%h want hi=%h lo=%h", oHi, oLo, eHi, eLo);
    end
  endtask

  task automatic test_ignored_start();
    logic [31:0] a, b;
    int extra;
    a = $urandom; b = $urandom;
    ref_model(MD_MULT, a, b);
    launch(MD_MULT, a, b);
    wait_done(10);
    total++;
    if (oLat != eLat || {oHi, oLo} !== {eHi, eLo}) begin
      bad++;
      $display("FAIL ignored_start: got lat=%0d hi=%h lo=%h want lat=%0d hi=%h lo=%h",
               oLat, oHi, oLo, eLat, eHi, eLo);
    end
    extra = oWidth - 1;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL ignored_start_extra_done: got %0d extra done want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    int lat;
    a1 = $urandom; b1 = $urandom;
    a2 = $urandom; b2 = $urandom | 32'd1;
    ref_model(MD_MULT, a1, b1);
    launch(MD_MULT, a1, b1);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat != eLat || {bus.hi_out, bus.lo_out} !== {eHi, eLo}) begin
      bad++;
      $display("FAIL b2b_first: got lat=%0d hi=%h lo=%h want lat=%0d hi=%h lo=%h",
               lat, bus.hi_out, bus.lo_out, eLat, eHi, eLo);
    end
    // Start raised during DONE (must be ignored) and held into IDLE (accepted)
    ref_model(MD_DIV, a2, b2);
    bus.start = 1'b1; bus.op = MD_DIV; bus.a_in = a2; bus.b_in = b2;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(0);
    total++;
    if (oLat != eLat || {oHi, oLo} !== {eHi, eLo}) begin
      bad++;
      $display("FAIL b2b_second: got lat=%0d hi=%h lo=%h want lat=%0d hi=%h lo=%h",
               oLat, oHi, oLo, eLat, eHi, eLo);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b;
    int seen;
    a = $urandom; b = $urandom | 32'd1;
    launch(MD_DIV, a, b);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    mHi = '0; mLo = '0;
    total++;
    if ({bus.busy, bus.done, bus.hi_write, bus.lo_write} !== 4'b0 || {bus.hi_out, bus.lo_out} !== 64'd0) begin
      bad++;
      $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want all 0",
               bus.busy, bus.done, bus.hi_out, bus.lo_out);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.hi_write === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_mid_no_done: got %0d done/write cycles want 0", seen);
    end
    a = $urandom; b = $urandom;
    ref_model(MD_MULT, a, b);
    launch(MD_MULT, a, b);
    wait_done(0);
    total++;
    if (oLat != eLat || {oHi, oLo} !== {eHi, eLo} || {oHw, oLw} !== 2'b11) begin
      bad++;
      $display("FAIL reset_mid_recover: got lat=%0d hi=%h lo=%h want lat=%0d hi=%h lo=%h",
               oLat, oHi, oLo, eLat, eHi, eLo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
